// File: rtl/spdif_tx.sv
// S/PDIF (IEC 60958 consumer) transmitter: one-entry stereo sample buffer feeding a
// biphase-mark serializer clocked by a one-cycle cell strobe at 128 x Fs.
module spdif_tx #(
  parameter int          DW      = 24,
  parameter logic [31:0] CS_WORD = 32'h0000_0000
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          cell_stb_i,
  input  logic [DW-1:0] left_i,
  input  logic [DW-1:0] right_i,
  input  logic          sample_valid_i,
  output logic          sample_ready_o,
  output logic          underrun_o,
  output logic          spdif_o
);

  localparam logic [7:0] PRE_B = 8'b1110_1000;
  localparam logic [7:0] PRE_M = 8'b1110_0010;
  localparam logic [7:0] PRE_W = 8'b1110_0100;

  // Place a DW-bit sample at the top of the 24-bit slot field, zero-filling the LSBs.
  function automatic logic [23:0] msb_align(input logic signed [DW-1:0] s);
    logic [23:0] w;
    w = '0;
    w[23 -: DW] = s;
    return w;
  endfunction

  logic                 buf_full;
  logic signed [DW-1:0] buf_l;
  logic signed [DW-1:0] buf_r;
  logic [23:0]          smp_l;
  logic [23:0]          smp_r;
  logic [5:0]           cell_cnt;
  logic                 sub;
  logic [7:0]           frame_cnt;
  logic                 pre_lvl;

  logic                 accept;
  logic                 frame_load;
  logic [4:0]           slot;
  logic [23:0]          word;
  logic                 c_bit;
  logic                 p_bit;
  logic                 data_bit;
  logic [7:0]           pre;
  logic                 pre_ref;
  logic                 cell_nxt;

  assign sample_ready_o = !buf_full;
  assign accept         = sample_valid_i && !buf_full;
  assign frame_load     = cell_stb_i && !sub && (cell_cnt == 6'd0);
  assign slot           = cell_cnt[5:1];
  assign word           = sub ? smp_r : smp_l;
  assign c_bit          = (frame_cnt < 8'd32) && CS_WORD[frame_cnt[4:0]];
  // V and U are always 0, so parity covers only the audio word and C.
  assign p_bit          = (^word) ^ c_bit;

  always_comb begin
    data_bit = 1'b0;
    if (slot >= 5'd4 && slot <= 5'd27) begin
      data_bit = word[5'(slot - 5'd4)];
    end else if (slot == 5'd30) begin
      data_bit = c_bit;
    end else if (slot == 5'd31) begin
      data_bit = p_bit;
    end
  end

  // Preamble cells are relative to the line level just before cell 0 of the subframe.
  always_comb begin
    pre      = sub ? PRE_W : ((frame_cnt == 8'd0) ? PRE_B : PRE_M);
    pre_ref  = (cell_cnt == 6'd0) ? spdif_o : pre_lvl;
    cell_nxt = 1'b0;
    if (cell_cnt < 6'd8) begin
      cell_nxt = pre[~cell_cnt[2:0]] ^ pre_ref;
    end else if (!cell_cnt[0]) begin
      cell_nxt = ~spdif_o;
    end else begin
      cell_nxt = spdif_o ^ data_bit;
    end
  end

  // Holding buffer data: only its occupancy flag needs a reset value.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      buf_l <= left_i;
      buf_r <= right_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_full   <= 1'b0;
      smp_l      <= '0;
      smp_r      <= '0;
      cell_cnt   <= '0;
      sub        <= 1'b0;
      frame_cnt  <= '0;
      pre_lvl    <= 1'b0;
      spdif_o    <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      underrun_o <= 1'b0;
      if (frame_load && buf_full) begin
        buf_full <= 1'b0;
      end else if (accept) begin
        buf_full <= 1'b1;
      end
      if (cell_stb_i) begin
        spdif_o  <= cell_nxt;
        cell_cnt <= cell_cnt + 6'd1;
        if (cell_cnt == 6'd0) begin
          pre_lvl <= spdif_o;
        end
        if (cell_cnt == 6'd63) begin
          sub <= ~sub;
          if (sub) begin
            frame_cnt <= (frame_cnt == 8'd191) ? 8'd0 : frame_cnt + 8'd1;
          end
        end
        // A frame with no buffered sample sends silence and flags the underrun.
        if (frame_load) begin
          smp_l      <= buf_full ? msb_align(buf_l) : 24'd0;
          smp_r      <= buf_full ? msb_align(buf_r) : 24'd0;
          underrun_o <= !buf_full;
        end
      end
    end
  end

endmodule

// File: tb/tb_spdif_tx.sv
// Self-checking bench for spdif_tx: a frame-level reference model builds each expected
// 128-cell frame from the subframe rules and the bench compares the serial output.
module tb_spdif_tx;

  localparam int          TB_DW = 24;
  localparam logic [31:0] TB_CS = 32'h0000_0004;

  logic             clk = 1'b0;
  logic             rst_n_i = 1'b1;
  logic             cell_stb_i = 1'b0;
  logic [TB_DW-1:0] left_i = '0;
  logic [TB_DW-1:0] right_i = '0;
  logic             sample_valid_i = 1'b0;
  logic             sample_ready_o;
  logic             underrun_o;
  logic             spdif_o;

  spdif_tx #(.DW(TB_DW), .CS_WORD(TB_CS)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n_i),
    .cell_stb_i     (cell_stb_i),
    .left_i         (left_i),
    .right_i        (right_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .underrun_o     (underrun_o),
    .spdif_o        (spdif_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model state
  int          mpos = 0;
  int          mfc = 0;
  logic        mbuf_full = 1'b0;
  logic [23:0] mbuf_l = '0;
  logic [23:0] mbuf_r = '0;
  logic [23:0] fr_l = '0;
  logic [23:0] fr_r = '0;
  logic        fr_und = 1'b0;
  logic        mlvl = 1'b0;
  logic [127:0] exp_vec = '0;
  logic [127:0] exp_und = '0;

  // Observations
  logic [127:0] obs_vec = '0;
  logic [127:0] obs_und = '0;
  logic         rdy0 = 1'b0;
  int           n_acc = 0;
  int           idle_chg = 0;
  int           idle_und = 0;
  int           rdy_bad = 0;

  localparam logic [7:0] B_CELLS = 8'b0001_0111;  // 11101000 sent first-to-last, bit i = cell i

  function automatic logic [23:0] align(input logic [TB_DW-1:0] s);
    return 24'(s) << (24 - TB_DW);
  endfunction

  task automatic model_reset();
    mpos = 0; mfc = 0; mbuf_full = 1'b0; mlvl = 1'b0;
  endtask

  // Expected cells for one whole frame, from slot contents and biphase-mark rules.
  task automatic build_frame();
    logic [27:0] bits;
    logic [7:0]  pre;
    logic [23:0] w;
    logic [31:0] cs_v;
    logic        lvl;
    logic        lref;
    int          idx;
    cs_v = TB_CS;
    lvl = mlvl;
    idx = 0;
    for (int s = 0; s < 2; s++) begin
      w = (s == 1) ? fr_r : fr_l;
      bits[23:0] = w;
      bits[24] = 1'b0;
      bits[25] = 1'b0;
      bits[26] = (mfc < 32) ? cs_v[mfc] : 1'b0;
      bits[27] = ^bits[26:0];
      pre = (s == 1) ? 8'b11100100 : ((mfc == 0) ? 8'b11101000 : 8'b11100010);
      lref = lvl;
      for (int k = 0; k < 8; k++) begin
        lvl = pre[7-k] ^ lref;
        exp_vec[idx] = lvl; idx++;
      end
      for (int b = 0; b < 28; b++) begin
        lvl = ~lvl;
        exp_vec[idx] = lvl; idx++;
        lvl = lvl ^ bits[b];
        exp_vec[idx] = lvl; idx++;
      end
    end
    mlvl = lvl;
    exp_und = '0;
    exp_und[0] = fr_und;
  endtask

  // One clock: drive inputs at a falling edge, update the model for the coming rising edge.
  // vm: 0 idle, 1 valid held (new data per accept), 2 random valid, 3 valid with caller data.
  task automatic tick(input logic stb, input int vm);
    logic hs;
    cell_stb_i = stb;
    case (vm)
      0:       sample_valid_i = 1'b0;
      1, 3:    sample_valid_i = 1'b1;
      default: sample_valid_i = ($urandom_range(0, 3) == 0);
    endcase
    if (sample_ready_o !== !mbuf_full) rdy_bad++;
    hs = sample_valid_i && sample_ready_o;
    if (stb && mpos == 0) begin
      fr_und = !mbuf_full;
      fr_l = mbuf_full ? mbuf_l : 24'd0;
      fr_r = mbuf_full ? mbuf_r : 24'd0;
      mbuf_full = 1'b0;
      build_frame();
    end
    if (hs) begin
      mbuf_full = 1'b1;
      mbuf_l = align(left_i);
      mbuf_r = align(right_i);
      n_acc++;
    end
    @(negedge clk);
    if (hs && (vm == 1 || vm == 2)) begin
      left_i = TB_DW'($urandom);
      right_i = TB_DW'($urandom);
    end
  endtask

  task automatic run_cells(input int n, input int gap, input int vm);
    logic last;
    idle_chg = 0; idle_und = 0; rdy_bad = 0; n_acc = 0;
    for (int k = 0; k < n; k++) begin
      tick(1'b1, vm);
      obs_vec[mpos] = spdif_o;
      obs_und[mpos] = underrun_o;
      if (mpos == 0) rdy0 = sample_ready_o;
      last = spdif_o;
      for (int g = 0; g < gap; g++) begin
        tick(1'b0, vm);
        if (spdif_o !== last) idle_chg++;
        if (underrun_o !== 1'b0) idle_und++;
      end
      mpos++;
      if (mpos == 128) begin
        mpos = 0;
        mfc = (mfc + 1) % 192;
      end
    end
  endtask

  task automatic preload(input logic [23:0] l, input logic [23:0] r);
    int a0;
    a0 = n_acc;
    left_i = l;
    right_i = r;
    for (int i = 0; i < 8 && n_acc == a0; i++) tick(1'b0, 3);
    sample_valid_i = 1'b0;
    n_checks++;
    if (n_acc == a0) $display("FAIL preload_accept: accepts got %0d want %0d", n_acc - a0, 1);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (spdif_o !== 1'b0) $display("FAIL reset_spdif: got %b want 0", spdif_o); else n_pass++;
    n_checks++; if (underrun_o !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun_o); else n_pass++;
    n_checks++; if (sample_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", sample_ready_o); else n_pass++;
    rst_n_i = 1'b1;
    model_reset();
    tick(1'b0, 0);
    run_cells(128, 3, 0);
    n_checks++; if (obs_vec[7:0] !== B_CELLS) $display("FAIL reset_preamble_B: got %b want %b", obs_vec[7:0], B_CELLS); else n_pass++;
    n_checks++; if (obs_und[0] !== 1'b1) $display("FAIL reset_underrun_pulse: got %b want 1", obs_und[0]); else n_pass++;
    n_checks++; if (obs_und !== exp_und) $display("FAIL reset_underrun_vec: got %h want %h", obs_und, exp_und); else n_pass++;
    n_checks++; if (obs_vec !== exp_vec) $display("FAIL reset_frame0: got %h want %h", obs_vec, exp_vec); else n_pass++;
    n_checks++; if (idle_chg !== 0) $display("FAIL reset_idle_change: got %0d want 0", idle_chg); else n_pass++;
    n_checks++; if (idle_und !== 0) $display("FAIL reset_underrun_width: got %0d want 0", idle_und); else n_pass++;
    n_checks++; if (rdy_bad !== 0) $display("FAIL reset_ready_track: got %0d want 0", rdy_bad); else n_pass++;
  endtask

  task automatic test_preload();
    preload(24'h000001, 24'h800000);
    run_cells(128, 1, 0);
    n_checks++; if (obs_vec !== exp_vec) $display("FAIL preload_frame: got %h want %h", obs_vec, exp_vec); else n_pass++;
    n_checks++; if ((obs_vec[8] ^ obs_vec[9]) !== 1'b1) $display("FAIL preload_left_slot4: got %b want 1", obs_vec[8] ^ obs_vec[9]); else n_pass++;
    n_checks++; if ((obs_vec[62] ^ obs_vec[63]) !== 1'b1) $display("FAIL preload_left_P: got %b want 1", obs_vec[62] ^ obs_vec[63]); else n_pass++;
    n_checks++; if ((obs_vec[118] ^ obs_vec[119]) !== 1'b1) $display("FAIL preload_right_slot27: got %b want 1", obs_vec[118] ^ obs_vec[119]); else n_pass++;
    n_checks++; if ((obs_vec[126] ^ obs_vec[127]) !== 1'b1) $display("FAIL preload_right_P: got %b want 1", obs_vec[126] ^ obs_vec[127]); else n_pass++;
    n_checks++; if (obs_vec[64 +: 8] !== 8'b0010_0111) $display("FAIL preload_W: got %b want %b", obs_vec[64 +: 8], 8'b0010_0111); else n_pass++;
    n_checks++; if (obs_vec[63] !== 1'b0 || obs_vec[127] !== 1'b0) $display("FAIL preload_preamble_level: got %b%b want 00", obs_vec[63], obs_vec[127]); else n_pass++;
    n_checks++; if (obs_und !== 128'd0) $display("FAIL preload_underrun: got %h want 0", obs_und); else n_pass++;
  endtask

  task automatic test_cs();
    preload(24'h000000, 24'h000000);
    run_cells(128, 1, 0);
    n_checks++; if (obs_vec !== exp_vec) $display("FAIL cs_frame2: got %h want %h", obs_vec, exp_vec); else n_pass++;
    n_checks++; if ((obs_vec[60] ^ obs_vec[61]) !== 1'b1) $display("FAIL cs_left_C: got %b want 1", obs_vec[60] ^ obs_vec[61]); else n_pass++;
    n_checks++; if ((obs_vec[124] ^ obs_vec[125]) !== 1'b1) $display("FAIL cs_right_C: got %b want 1", obs_vec[124] ^ obs_vec[125]); else n_pass++;
    n_checks++; if ((obs_vec[62] ^ obs_vec[63]) !== 1'b1) $display("FAIL cs_left_P: got %b want 1", obs_vec[62] ^ obs_vec[63]); else n_pass++;
    n_checks++; if ((obs_vec[126] ^ obs_vec[127]) !== 1'b1) $display("FAIL cs_right_P: got %b want 1", obs_vec[126] ^ obs_vec[127]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    preload(24'($urandom), 24'($urandom));
    for (int f = 0; f < 8; f++) begin
      run_cells(128, 1, 1);
      n_checks++; if (n_acc !== 1) $display("FAIL b2b_accepts f=%0d: got %0d want 1", f, n_acc); else n_pass++;
      n_checks++; if (rdy0 !== 1'b1) $display("FAIL b2b_ready_after_load f=%0d: got %b want 1", f, rdy0); else n_pass++;
      n_checks++; if (rdy_bad !== 0) $display("FAIL b2b_ready_track f=%0d: got %0d want 0", f, rdy_bad); else n_pass++;
      n_checks++; if (obs_und !== 128'd0) $display("FAIL b2b_underrun f=%0d: got %h want 0", f, obs_und); else n_pass++;
      n_checks++; if (obs_vec !== exp_vec) $display("FAIL b2b_frame f=%0d: got %h want %h", f, obs_vec, exp_vec); else n_pass++;
    end
    sample_valid_i = 1'b0;
  endtask

  task automatic test_wrap();
    int fnum;
    while (mfc != 0 || fnum == 0) begin
      fnum = mfc;
      run_cells(128, 1, 2);
      n_checks++; if (obs_vec !== exp_vec) $display("FAIL wrap_frame fc=%0d: got %h want %h", fnum, obs_vec, exp_vec); else n_pass++;
      n_checks++; if (obs_und !== exp_und) $display("FAIL wrap_underrun fc=%0d: got %h want %h", fnum, obs_und, exp_und); else n_pass++;
      n_checks++; if (rdy_bad !== 0) $display("FAIL wrap_ready_track fc=%0d: got %0d want 0", fnum, rdy_bad); else n_pass++;
      if (fnum == 0) begin
        n_checks++; if (obs_vec[7:0] !== B_CELLS) $display("FAIL wrap_B_after_191: got %b want %b", obs_vec[7:0], B_CELLS); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    run_cells(128, 1, 0);
    n_checks++; if (obs_vec !== exp_vec) $display("FAIL mid_drain_frame: got %h want %h", obs_vec, exp_vec); else n_pass++;
    preload(24'h000001, 24'($urandom));
    run_cells(31, 1, 0);
    n_checks++; if (obs_vec[30:0] !== exp_vec[30:0]) $display("FAIL mid_cells_0_30: got %h want %h", obs_vec[30:0], exp_vec[30:0]); else n_pass++;
    n_checks++; if (spdif_o !== 1'b1) $display("FAIL mid_level_before_reset: got %b want 1", spdif_o); else n_pass++;
    #2 rst_n_i = 1'b0;
    #1;
    n_checks++; if (spdif_o !== 1'b0) $display("FAIL mid_async_spdif: got %b want 0", spdif_o); else n_pass++;
    n_checks++; if (sample_ready_o !== 1'b1) $display("FAIL mid_async_ready: got %b want 1", sample_ready_o); else n_pass++;
    @(negedge clk);
    rst_n_i = 1'b1;
    model_reset();
    tick(1'b0, 0);
    run_cells(8, 1, 0);
    n_checks++; if (obs_vec[7:0] !== B_CELLS) $display("FAIL mid_restart_B: got %b want %b", obs_vec[7:0], B_CELLS); else n_pass++;
    n_checks++; if (obs_und[0] !== 1'b1) $display("FAIL mid_restart_underrun: got %b want 1", obs_und[0]); else n_pass++;
    n_checks++; if (rdy_bad !== 0) $display("FAIL mid_ready_track: got %0d want 0", rdy_bad); else n_pass++;
  endtask

  initial begin
    #1;
    test_reset();
    test_preload();
    test_cs();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/spdif_tx.md
Name: spdif_tx

Overview:
- S/PDIF (IEC 60958 consumer) transmitter. It is the transmit end of the S/PDIF link; the receive path uses the strobe CDC.
- Takes stereo PCM samples over a valid/ready handshake and produces the biphase-mark encoded serial stream on one output pin.
- Runs in a single system clock domain. A one-cycle strobe sets the timing at the biphase cell rate, 128 x Fs.
- Sits in front of the optical/coax output driver.

Parameters:
- DW, 24: audio sample width, 16..24. Samples are MSB-aligned into the 24-bit slot field; unused LSBs are sent as 0.
- CS_WORD, 32'h0000_0000: channel status bits 0..31. Bit i is sent in frame i. Channel status bits 32..191 are 0.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- cell_stb_i  in  1  one-cycle strobe per biphase cell (128 x Fs); at least 2 clk_i cycles apart
- left_i  in  DW  left sample, two's complement
- right_i  in  DW  right sample, two's complement
- sample_valid_i  in  1  left_i/right_i valid
- sample_ready_o  out  1  holding buffer empty; sample accepted when valid && ready
- underrun_o  out  1  one-cycle pulse: frame started with no buffered sample
- spdif_o  out  1  biphase-mark serial output

Behaviour:
- Reset values (asynchronous): spdif_o=0, underrun_o=0, sample_ready_o=1. Counters cell_cnt=0, sub=0 (left), frame_cnt=0. Buffer empty; shift registers zero.
- State changes only on clk_i edges with cell_stb_i=1, except buffer accept and underrun_o clear.
- Latency: spdif_o is registered. It holds the value of cell n starting from the clk_i edge on which the n-th cell_stb_i is sampled.
- Counters advance after every cell:
  - cell_cnt runs 0..63 within a subframe.
  - sub toggles when cell_cnt wraps 63->0.
  - frame_cnt runs 0..191 and increments when sub wraps 1->0. After 191 it wraps to 0.
- Subframe structure, 32 slots of 2 cells each:
  - Slots 0-3 (cells 0-7): preamble.
  - Slots 4-27: audio, LSB first. 24-bit word = {sample, (24-DW) zeros}.
  - Slot 28: V=0.
  - Slot 29: U=0.
  - Slot 30: C = CS_WORD[frame_cnt] if frame_cnt<32, else 0.
  - Slot 31: P, even parity over slots 4-30, so slots 4-31 contain an even number of ones.
- Preamble selection, as 8-cell pattern sent MSB first:
  - B=8'b11101000 when sub=0 and frame_cnt=0.
  - M=8'b11100010 when sub=0 and frame_cnt!=0.
  - W=8'b11100100 when sub=1.
  - Each emitted cell = pattern bit XOR L, where L is the spdif_o level latched just before cell 0 of that subframe.
- Data slot encoding (slots 4-31), with current level lvl:
  - First cell = ~lvl.
  - Second cell = first cell XOR bit.
  - This gives a transition at every bit boundary, plus a mid-bit transition for a 1.
- Buffer and handshake:
  - One-entry holding register {left, right}; sample_ready_o = !buf_full.
  - Accept on any clk_i with sample_valid_i && sample_ready_o. Independent of cell_stb_i.
- Frame load, on the cell_stb_i edge that emits cell 0 of a left subframe:
  - If buf_full: buffer moves to the output sample registers and buf_full clears. sample_ready_o is 1 on the next cycle.
  - If empty: output sample registers load zero and underrun_o pulses for that one cycle.
- Simultaneous accept and frame load with an empty buffer: the accepted sample goes into the buffer for the next frame. The current frame sends zero and underrun_o pulses.
- The right sample is held in its register and serialized in the right subframe of the same frame.
- Reset mid-operation: all state returns to reset values immediately. The first cell_stb_i after release starts a B preamble with frame_cnt=0.
- cell_stb_i held high continuously is illegal. Behaviour then is undefined but must not lock up.

Test Plan:
- Reset, no valid, cell_stb_i every 4 clocks -> cells 0-7 = 11101000, underrun_o one pulse at cell 0, audio slots all 0, P=0. spdif_o changes only one clk after a strobe.
- Preload left=24'h000001, right=24'h800000, DW=24 -> left slot 4 shows a mid-bit transition, left P=1. Right W preamble, slot 27 = 1, P=1. Line level at each preamble start is identical.
- Run 193 frames -> B at frames 0 and 192. M on all other left subframes, W on every right subframe. frame_cnt wraps 191->0.
- CS_WORD=32'h0000_0004 -> C=1 only in frame 2, both subframes. Parity is adjusted accordingly.
- Hold sample_valid_i high -> first accept sets sample_ready_o=0. Ready returns to 1 the cycle after each frame load. Exactly one accept per frame, no underrun.
- Assert rst_n_i low mid-subframe, at cell 30 -> spdif_o=0 asynchronously. After release the next strobes emit B preamble 11101000.
